// File: rtl/fp_cmp_pipe_pkg.sv
// Shared types and helpers for the pipelined floating-point compare/min/max unit.
package fp_cmp_pkg;

  // Operation select; encodings 5..7 are reserved and produce a zero result.
  typedef enum logic [2:0] {
    FCMP_EQ  = 3'd0,
    FCMP_LT  = 3'd1,
    FCMP_LE  = 3'd2,
    FCMP_MIN = 3'd3,
    FCMP_MAX = 3'd4
  } fp_op_e;

  // Per-operand classification produced by fp_classify.
  typedef struct packed {
    logic is_zero;
    logic is_inf;
    logic is_nan;
    logic is_snan;
    logic sign;
  } fp_class_t;

  localparam int unsigned FP_MAX_W = 64;

  // Canonical quiet NaN: sign 0, exponent all ones, mantissa MSB set, rest zero.
  function automatic logic [FP_MAX_W-1:0] canon_qnan(input int unsigned exp_w,
                                                     input int unsigned man_w);
    logic [FP_MAX_W-1:0] exp_ones;
    exp_ones = (64'd1 << exp_w) - 64'd1;
    return (exp_ones << man_w) | (64'd1 << (man_w - 1));
  endfunction

endpackage

// File: rtl/fp_cmp_pipe_if.sv
// Operand-issue and result handshake bundle between the FPU issue stage, this unit and writeback.
interface fp_cmp_pipe_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [2:0]   in_op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_res;
  logic         out_nv;

  // Upstream issue / downstream writeback side.
  modport master (
    output in_valid, in_a, in_b, in_op, out_ready,
    input  in_ready, out_valid, out_res, out_nv
  );

  // Compare unit side.
  modport slave (
    input  in_valid, in_a, in_b, in_op, out_ready,
    output in_ready, out_valid, out_res, out_nv
  );
endinterface

// File: rtl/fp_classify.sv
// Combinational IEEE-754 operand classifier (zero / inf / NaN / sNaN / sign).
module fp_classify
  import fp_cmp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [EXP_W+MAN_W:0] op_i,
  output fp_class_t            cls_o
);
  logic [EXP_W-1:0] exp_f;
  logic [MAN_W-1:0] man_f;
  logic             exp_ones;
  logic             man_zero;

  assign exp_f    = op_i[MAN_W +: EXP_W];
  assign man_f    = op_i[MAN_W-1:0];
  assign exp_ones = &exp_f;
  assign man_zero = (man_f == '0);

  assign cls_o.sign    = op_i[EXP_W+MAN_W];
  assign cls_o.is_zero = (exp_f == '0) && man_zero;
  assign cls_o.is_inf  = exp_ones && man_zero;
  assign cls_o.is_nan  = exp_ones && !man_zero;
  // A NaN is signalling when the quiet bit (mantissa MSB) is clear.
  assign cls_o.is_snan = exp_ones && !man_zero && !man_f[MAN_W-1];
endmodule

// File: rtl/fp_cmp_pipe.sv
// Pipelined IEEE-754 EQ/LT/LE/MIN/MAX unit with valid/ready handshake and sticky invalid flag.
module fp_cmp_pipe
  import fp_cmp_pkg::*;
#(
  parameter int EXP_W  = 8,
  parameter int MAN_W  = 23,
  parameter int STAGES = 2   // 2: classify/compare reg + output reg; any other value: output reg only
) (
  input  logic          clk,
  input  logic          rst_n,
  fp_cmp_pipe_if.slave  bus,
  output logic          nv_sticky,
  input  logic          nv_clr
);
  localparam int W = 1 + EXP_W + MAN_W;
  localparam int M = EXP_W + MAN_W;
  localparam logic [W-1:0] QNAN = W'(canon_qnan(EXP_W, MAN_W));

  // Everything the result stage needs, captured at the classify/compare boundary.
  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    fp_op_e       op;
    logic         nan_a;
    logic         nan_b;
    logic         snan_a;
    logic         snan_b;
    logic         zero_both;
    logic         lt;   // a orders strictly below b (meaningless if either is NaN)
    logic         eq;   // a and b order equal   (meaningless if either is NaN)
  } stage_t;

  fp_class_t    cls_a, cls_b;
  stage_t       stage_d, src;
  logic         src_valid;
  logic         in_ready;
  logic         out_adv;
  logic         out_valid_q;
  logic [W-1:0] out_res_q, res_d;
  logic         out_nv_q, nv_d;
  logic         nv_sticky_q;
  logic         any_nan, any_snan;
  logic         unused_inf;

  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (.op_i(bus.in_a), .cls_o(cls_a));
  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (.op_i(bus.in_b), .cls_o(cls_b));

  // Infinities need no special case: their magnitude already orders above every finite value.
  assign unused_inf = cls_a.is_inf ^ cls_b.is_inf;

  // Sign-magnitude ordering and capture of the classification bits.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    stage_d           = '0;
    stage_d.a         = bus.in_a;
    stage_d.b         = bus.in_b;
    stage_d.op        = fp_op_e'(bus.in_op);
    stage_d.nan_a     = cls_a.is_nan;
    stage_d.nan_b     = cls_b.is_nan;
    stage_d.snan_a    = cls_a.is_snan;
    stage_d.snan_b    = cls_b.is_snan;
    stage_d.zero_both = cls_a.is_zero && cls_b.is_zero;
    if (cls_a.is_zero && cls_b.is_zero) begin
      stage_d.eq = 1'b1;
    end else if (cls_a.sign != cls_b.sign) begin
      stage_d.lt = cls_a.sign;
    end else begin
      stage_d.eq = (bus.in_a[M-1:0] == bus.in_b[M-1:0]);
      stage_d.lt = cls_a.sign ? (bus.in_a[M-1:0] > bus.in_b[M-1:0])
                              : (bus.in_a[M-1:0] < bus.in_b[M-1:0]);
    end
  end

  // Output register can take a new beat when empty or when its result is consumed.
  assign out_adv = !out_valid_q || bus.out_ready;

  if (STAGES == 2) begin : g_two
    stage_t s1_q;
    logic   s1_valid_q;

    // Classify/compare register.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
        s1_valid_q <= 1'b0;
        s1_q       <= '0;
      end else if (in_ready) begin
        s1_valid_q <= bus.in_valid;
        if (bus.in_valid) s1_q <= stage_d;
      end
    end

    assign in_ready  = !s1_valid_q || out_adv;
    assign src_valid = s1_valid_q;
    assign src       = s1_q;
  end else begin : g_one
    assign in_ready  = out_adv;
    assign src_valid = bus.in_valid;
    assign src       = stage_d;
  end

  // Result select: compare bit, min/max operand choice, NaN and signed-zero handling.
  always_comb begin
    res_d    = '0;
    nv_d     = 1'b0;
    any_nan  = src.nan_a || src.nan_b;
    any_snan = src.snan_a || src.snan_b;
    case (src.op)
      FCMP_EQ: begin
        res_d[0] = !any_nan && src.eq;
        nv_d     = any_snan;
      end
      FCMP_LT: begin
        res_d[0] = !any_nan && src.lt;
        nv_d     = any_nan;
      end
      FCMP_LE: begin
        res_d[0] = !any_nan && (src.lt || src.eq);
        nv_d     = any_nan;
      end
      FCMP_MIN, FCMP_MAX: begin
        nv_d = any_snan;
        if (src.nan_a && src.nan_b)  res_d = QNAN;
        else if (src.nan_a)          res_d = src.b;
        else if (src.nan_b)          res_d = src.a;
        // Zeros: MIN prefers the negative one, MAX the positive one, whatever the order.
        else if (src.zero_both)      res_d = ((src.op == FCMP_MIN) == src.a[W-1]) ? src.a : src.b;
        else if (src.op == FCMP_MIN) res_d = (src.lt || src.eq) ? src.a : src.b;
        else                         res_d = src.lt ? src.b : src.a;
      end
      default: ;
    endcase
  end

  // Output register; result and flag hold while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_res_q   <= '0;
      out_nv_q    <= 1'b0;
    end else if (out_adv) begin
      out_valid_q <= src_valid;
      if (src_valid) begin
        out_res_q <= res_d;
        out_nv_q  <= nv_d;
      end
    end
  end

  // Sticky invalid flag: a consumed nv result sets it and beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nv_sticky_q <= 1'b0;
    end else if (out_valid_q && bus.out_ready && out_nv_q) begin
      nv_sticky_q <= 1'b1;
    end else if (nv_clr) begin
      nv_sticky_q <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_res   = out_res_q;
  assign bus.out_nv    = out_nv_q;
  assign nv_sticky     = nv_sticky_q;
endmodule

// File: tb/tb_fp_cmp_pipe.sv
// Directed bench for fp_cmp_pipe at single-precision defaults with two pipeline stages.
module tb_fp_cmp_pipe;
  import fp_cmp_pkg::*;

  localparam int EXP_W  = 8;
  localparam int MAN_W  = 23;
  localparam int STAGES = 2;
  localparam int NV     = 24;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic nv_clr = 1'b0;
  logic nv_sticky;

  fp_cmp_pipe_if #(.EXP_W(EXP_W), .MAN_W(MAN_W)) bus ();

  fp_cmp_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .nv_sticky (nv_sticky),
    .nv_clr    (nv_clr)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [31:0] res;
    logic        nv;
  } vec_t;

  vec_t        vecs [NV];
  logic [31:0] exp_q [8];
  logic        exp_sticky;
  logic [31:0] got_res;
  logic        got_nv;
  int          lat;
  int          guard;
  int          p_idx, p_cyc;
  int          c_got, c_cyc;
  logic        p_acc;
  logic        stalled_prev;
  logic [31:0] held_res;
  logic        held_nv;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Issue one beat with out_ready high; return the result, its nv and the accept-to-valid latency.
  task automatic run_beat(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                          output logic [31:0] res, output logic nv, output int latency);
    int g;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_op    = op;
    bus.in_valid = 1'b1;
    g = 0;
    @(negedge clk);
    while (!bus.in_ready && g < 20) begin
      @(negedge clk);
      g++;
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    latency = 0;
    res     = 'x;
    nv      = 1'bx;
    do begin
      @(negedge clk);
      latency++;
    end while (!bus.out_valid && latency < 20);
    if (bus.out_valid) begin
      res = bus.out_res;
      nv  = bus.out_nv;
    end else begin
      latency = -1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    // {a, b, op, expected res, expected nv}; op 0=EQ 1=LT 2=LE 3=MIN 4=MAX
    vecs[0]  = '{32'h3F800000, 32'h40000000, 3'd2, 32'h00000001, 1'b0}; // 1.0 <= 2.0
    vecs[1]  = '{32'h40000000, 32'h3F800000, 3'd1, 32'h00000000, 1'b0}; // 2.0 < 1.0
    vecs[2]  = '{32'h80000000, 32'h00000000, 3'd0, 32'h00000001, 1'b0}; // -0 == +0
    vecs[3]  = '{32'h80000000, 32'h00000000, 3'd3, 32'h80000000, 1'b0}; // min(-0,+0)
    vecs[4]  = '{32'h00000000, 32'h80000000, 3'd4, 32'h00000000, 1'b0}; // max(+0,-0)
    vecs[5]  = '{32'h00000000, 32'h80000000, 3'd3, 32'h80000000, 1'b0}; // min(+0,-0)
    vecs[6]  = '{32'h80000000, 32'h00000000, 3'd4, 32'h00000000, 1'b0}; // max(-0,+0)
    vecs[7]  = '{32'hC0000000, 32'hBF800000, 3'd1, 32'h00000001, 1'b0}; // -2 < -1
    vecs[8]  = '{32'h00000001, 32'h00800000, 3'd2, 32'h00000001, 1'b0}; // subnormal <= min normal
    vecs[9]  = '{32'h7F800000, 32'h7F800000, 3'd0, 32'h00000001, 1'b0}; // inf == inf
    vecs[10] = '{32'hBF800000, 32'h3F800000, 3'd3, 32'hBF800000, 1'b0}; // min(-1,1)
    vecs[11] = '{32'h3F800000, 32'h3F800000, 3'd2, 32'h00000001, 1'b0}; // 1 <= 1
    vecs[12] = '{32'h3F800000, 32'h3F800000, 3'd1, 32'h00000000, 1'b0}; // 1 < 1
    vecs[13] = '{32'h7FC00000, 32'h3F800000, 3'd1, 32'h00000000, 1'b1}; // LT with qNaN
    vecs[14] = '{32'h7FC00000, 32'h3F800000, 3'd0, 32'h00000000, 1'b0}; // EQ with qNaN
    vecs[15] = '{32'h7F800001, 32'hC0000000, 3'd3, 32'hC0000000, 1'b1}; // min(sNaN,-2)
    vecs[16] = '{32'h7FC00000, 32'h7F800001, 3'd4, 32'h7FC00000, 1'b1}; // max(qNaN,sNaN)
    vecs[17] = '{32'h3F800000, 32'h7FC00001, 3'd3, 32'h3F800000, 1'b0}; // min(1,qNaN)
    vecs[18] = '{32'hFFC00000, 32'h7FC00001, 3'd4, 32'h7FC00000, 1'b0}; // both qNaN -> canonical
    vecs[19] = '{32'h7F800001, 32'h7F800001, 3'd0, 32'h00000000, 1'b1}; // EQ sNaN
    vecs[20] = '{32'h7F800001, 32'h00000000, 3'd5, 32'h00000000, 1'b0}; // reserved op
    vecs[21] = '{32'hFF800000, 32'h80000001, 3'd2, 32'h00000001, 1'b0}; // -inf <= -tiny
    vecs[22] = '{32'h40000000, 32'hC0000000, 3'd4, 32'h40000000, 1'b0}; // max(2,-2)
    vecs[23] = '{32'h7F800000, 32'h7F7FFFFF, 3'd2, 32'h00000000, 1'b0}; // inf <= max finite

    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_op     = '0;
    bus.out_ready = 1'b1;

    // Reset state
    #12;
    check("reset out_valid", bus.out_valid, 0);
    check("reset out_res", bus.out_res, 0);
    check("reset out_nv", bus.out_nv, 0);
    check("reset nv_sticky", nv_sticky, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("in_ready after release", bus.in_ready, 1);

    // Table-driven single beats
    exp_sticky = 1'b0;
    for (int i = 0; i < NV; i++) begin
      run_beat(vecs[i].a, vecs[i].b, vecs[i].op, got_res, got_nv, lat);
      exp_sticky = exp_sticky | vecs[i].nv;
      check($sformatf("vec%0d res", i), got_res, vecs[i].res);
      check($sformatf("vec%0d nv", i), got_nv, vecs[i].nv);
      check($sformatf("vec%0d latency", i), lat, STAGES);
      check($sformatf("vec%0d nv_sticky", i), nv_sticky, exp_sticky);
      check($sformatf("vec%0d drained", i), bus.out_valid, 0);
    end

    // Back-to-back stream of 8 beats with a 4-cycle output stall in the middle
    for (int i = 0; i < 8; i++) exp_q[i] = 32'h3F800000 + 32'(i) * 32'h100;
    fork
      begin
        p_idx = 0;
        p_cyc = 0;
        while (p_idx < 8 && p_cyc < 100) begin
          bus.in_a     = exp_q[p_idx];
          bus.in_b     = 32'h00000000;
          bus.in_op    = 3'd4;
          bus.in_valid = 1'b1;
          @(negedge clk);
          p_acc = bus.in_ready;
          @(posedge clk);
          #1;
          if (p_acc) p_idx++;
          p_cyc++;
        end
        bus.in_valid = 1'b0;
      end
      begin
        c_got        = 0;
        c_cyc        = 0;
        stalled_prev = 1'b0;
        while (c_got < 8 && c_cyc < 100) begin
          bus.out_ready = !(c_cyc >= 3 && c_cyc <= 6);
          @(negedge clk);
          if (bus.out_valid && !bus.out_ready) begin
            check($sformatf("stall in_ready c%0d", c_cyc), bus.in_ready, 0);
            if (stalled_prev) begin
              check($sformatf("stall hold res c%0d", c_cyc), bus.out_res, held_res);
              check($sformatf("stall hold nv c%0d", c_cyc), bus.out_nv, held_nv);
            end
            held_res     = bus.out_res;
            held_nv      = bus.out_nv;
            stalled_prev = 1'b1;
          end else begin
            stalled_prev = 1'b0;
          end
          if (bus.out_valid && bus.out_ready) begin
            check($sformatf("stream res %0d", c_got), bus.out_res, exp_q[c_got]);
            c_got++;
          end
          @(posedge clk);
          #1;
          c_cyc++;
        end
      end
    join
    check("stream beats accepted", p_idx, 8);
    check("stream beats received", c_got, 8);
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("stream no extra beat", bus.out_valid, 0);
    check("stream nv_sticky unchanged", nv_sticky, exp_sticky);

    // Clear alone, then set wins over a simultaneous clear, then clear again
    nv_clr = 1'b1;
    @(posedge clk);
    #1 nv_clr = 1'b0;
    check("nv_clr alone", nv_sticky, 0);
    bus.out_ready = 1'b0;
    bus.in_a      = 32'h7FC00000;
    bus.in_b      = 32'h3F800000;
    bus.in_op     = 3'd1;
    bus.in_valid  = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!bus.out_valid && guard < 10);
    check("clr-race out_valid", bus.out_valid, 1);
    check("clr-race out_nv", bus.out_nv, 1);
    check("clr-race sticky before", nv_sticky, 0);
    bus.out_ready = 1'b1;
    nv_clr        = 1'b1;
    @(posedge clk);
    #1 nv_clr = 1'b0;
    check("set wins over clr", nv_sticky, 1);
    nv_clr = 1'b1;
    @(posedge clk);
    #1 nv_clr = 1'b0;
    check("clr next cycle", nv_sticky, 0);

    // Reset with two beats in flight
    bus.out_ready = 1'b0;
    bus.in_a      = 32'h40400000;
    bus.in_b      = 32'h00000000;
    bus.in_op     = 3'd4;
    bus.in_valid  = 1'b1;
    @(posedge clk);
    #1;
    bus.in_a  = 32'h7FC00000;
    bus.in_op = 3'd1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    check("inflight out_valid", bus.out_valid, 1);
    check("inflight out_res", bus.out_res, 32'h40400000);
    rst_n = 1'b0;
    #1;
    check("async reset out_valid", bus.out_valid, 0);
    check("async reset out_res", bus.out_res, 0);
    check("async reset out_nv", bus.out_nv, 0);
    @(negedge clk);
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("post-reset in_ready", bus.in_ready, 1);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("post-reset no stale %0d", i), bus.out_valid, 0);
      @(posedge clk);
      #1;
    end
    check("post-reset nv_sticky", nv_sticky, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fp_cmp_pipe.md
Name: fp_cmp_pipe

Overview:
- Parametrised, pipelined IEEE-754 compare/min/max unit for the FPU; successor to the single-precision combinational less-or-equal compare.
- Adds configurable format width and selectable ops (EQ/LT/LE/MIN/MAX).
- Implements correct NaN and signed-zero semantics, exception signalling, a valid/ready handshake and a sticky invalid flag.
- Sits between the FPU operand issue stage and FPU writeback.

Parameters:
- EXP_W, 8, exponent field width.
- MAN_W, 23, mantissa field width; W = 1+EXP_W+MAN_W.
- STAGES, 2, pipeline depth, legal values 1 or 2. 1 = single output register; 2 = classify/compare register + output register.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  unit can accept a beat.
- in_a  in  W  operand A.
- in_b  in  W  operand B.
- in_op  in  3  0=EQ, 1=LT, 2=LE, 3=MIN, 4=MAX, 5..7 reserved.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_res  out  W  compare: {W-1 zeros, bit}; MIN/MAX: selected operand or canonical NaN.
- out_nv  out  1  invalid-operation flag for this result.
- nv_sticky  out  1  accumulated invalid flag.
- nv_clr  in  1  clear nv_sticky.

Behaviour:
- Reset (async assert, sync release): all stage valids 0, out_valid=0, out_res=0, out_nv=0, nv_sticky=0. In-flight beats are discarded. in_ready=1 in the first cycle after release.
- Handshake: a beat is accepted when in_valid && in_ready; a result is consumed when out_valid && out_ready.
- Each stage advances when it is empty or the stage after it advances. in_ready = !stage1_valid || stage1_advances (combinational from out_ready, no comb path from in_valid).
- Unstalled latency = STAGES cycles from accept to out_valid; throughput 1 beat/cycle; no bubbles when out_ready is held high.
- While out_valid && !out_ready, out_res and out_nv are held stable.
- Classification per operand:
  - zero: exp=0, man=0.
  - NaN: exp all ones, man!=0.
  - sNaN: NaN with man MSB=0.
  - qNaN: NaN with man MSB=1.
  - infinity: exp all ones, man=0.
  - subnormals compare by magnitude; no flush.
- Ordering: sign-magnitude. Both zero (any signs) => equal. Otherwise if signs differ, negative < positive. If both positive, larger {exp,man} is greater; if both negative, order is reversed.
- EQ: 1 iff neither operand is NaN and values are equal. nv=1 iff either operand is sNaN.
- LT/LE: 0 if either operand is NaN. nv=1 if either operand is any NaN (signalling compare).
- MIN/MAX:
  - One operand NaN: return the other operand.
  - Both NaN: return canonical qNaN (sign 0, exp all ones, man = 1 followed by zeros; 0x7FC00000 at defaults).
  - min(-0,+0) = -0 and max(-0,+0) = +0, independent of operand order.
  - Equal non-zero values return A.
  - nv=1 iff either operand is sNaN.
- Reserved op: out_res=0, out_nv=0.
- nv_sticky update occurs when a result is consumed:
  - Set when out_nv=1.
  - Cleared by nv_clr.
  - Consumption with out_nv=1 in the same cycle as nv_clr leaves nv_sticky=1 (set wins).
- Width rules: all compares are unsigned on {exp,man} (EXP_W+MAN_W bits); no arithmetic, no overflow.

Decomposition:
- Shared package fp_cmp_pkg:
  - op enum (FCMP_EQ..FCMP_MAX).
  - Class struct {is_zero, is_inf, is_nan, is_snan, sign}.
  - Function returning canonical qNaN for (EXP_W, MAN_W).
- Sub-module fp_classify (combinational, one instance per operand, parameterised EXP_W/MAN_W). Top holds the pipeline registers, compare/select logic and the sticky flag.

Test Plan:
- LE A=0x3F800000 (1.0), B=0x40000000 (2.0), out_ready=1 -> out_valid 2 cycles after accept, out_res=0x00000001, out_nv=0; LT with A/B swapped -> 0x00000000.
- EQ A=0x80000000, B=0x00000000 -> res=1, nv=0; MIN of same -> 0x80000000; MAX with A/B swapped -> 0x00000000.
- LT A=0x7FC00000, B=0x3F800000 -> res=0, nv=1, nv_sticky=1 on consume; EQ same operands -> res=0, nv=0.
- MIN A=0x7F800001 (sNaN), B=0xC0000000 -> res=0xC0000000, nv=1; MAX A=0x7FC00000, B=0x7F800001 -> res=0x7FC00000, nv=1.
- Back-to-back 8 beats with out_ready=0 for 4 cycles mid-stream -> in_ready drops after STAGES beats are held, no beat lost or duplicated, results in order, out_res stable while stalled.
- nv_clr asserted in the same cycle as consuming an nv=1 result -> nv_sticky=1; nv_clr alone next cycle -> 0. Assert rst_n low with 2 beats in flight -> out_valid=0 immediately, no stale result after release.
